// File: rtl/fpu_types.sv
// Shared FPU types for the misc pipe: operand bundle, writeback payload,
// buffer entry and canonical NaN encodings.
package fpu_types;

    localparam int FLEN          = 64;
    localparam int FLEN_F        = 32;
    localparam int EXPO_WIDTH    = 11;
    localparam int FRAC_WIDTH    = 52;
    localparam int BIAS          = 1023;
    localparam int MAX_INT_WIDTH = 64;
    localparam int CLZ_WIDTH     = $clog2(MAX_INT_WIDTH) + 1;
    localparam int ID_WIDTH      = 4;
    localparam int NV_BIT        = 4;

    localparam logic [FLEN-1:0]   CANONICAL_NAN   = 64'h7FF8_0000_0000_0000;
    localparam logic [FLEN_F-1:0] CANONICAL_NAN_F = 32'h7FC0_0000;

    typedef logic [ID_WIDTH-1:0] id_t;

    typedef struct packed {
        logic is_nan;
        logic is_snan;
        logic is_zero;
    } fp_special_t;

    // Integer fields are sized for the widest integer path; a 32-bit
    // instance only looks at the low 32 bits.
    typedef struct packed {
        logic                     fmv;
        logic                     d2s;
        logic                     fsgnj;
        logic                     fminmax;
        logic                     i2f;
        logic                     s2d;
        logic [FLEN-1:0]          rs1;
        logic [FLEN-1:0]          rs2;
        fp_special_t              rs1_special;
        fp_special_t              rs2_special;
        logic [2:0]               rm;
        logic [MAX_INT_WIDTH-1:0] int_rs;
        logic [MAX_INT_WIDTH-1:0] int_rs_abs;
        logic                     i2f_sign;
        logic                     swap;
        logic                     single;
    } fp_misc_pipe_inputs_t;

    typedef struct packed {
        logic [FLEN-1:0]      rd;
        logic                 hidden;
        logic [2:0]           grs;
        logic [CLZ_WIDTH-1:0] clz;
        logic [4:0]           fflags;
        logic                 d2s;
        logic [2:0]           rm;
        logic                 expo_overflow;
        logic                 carry;
        logic                 safe;
        logic                 right_shift;
        logic                 subnormal;
        logic                 ignore_max_expo;
    } fp_misc_wb_payload_t;

    typedef struct packed {
        id_t                 id;
        fp_misc_wb_payload_t payload;
    } fp_misc_entry_t;

    // A single is NaN-boxed when the upper half is all ones.
    function automatic logic is_boxed(input logic [FLEN-1:0] v);
        return &v[FLEN-1:FLEN_F];
    endfunction

    // rm[1] = JX, rm[0] = JN, otherwise plain J.
    function automatic logic sgnj_sign(input logic [2:0] rm, input logic a, input logic b);
        if (rm[1])
            return a ^ b;
        else if (rm[0])
            return ~b;
        else
            return b;
    endfunction

endpackage

// File: rtl/clz.sv
// Leading-zero counter; an all-zero input reports WIDTH.
module clz #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]       value,
    output logic [$clog2(WIDTH):0] count
);

    localparam int CW = $clog2(WIDTH) + 1;

    // Highest set bit wins because later iterations override earlier ones.
    always_comb begin
        count = CW'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (value[i])
                count = CW'(WIDTH - 1 - i);
        end
    end

endmodule

// File: rtl/fp_misc_fifo.sv
// Result buffer: DEPTH-entry circular FIFO of an arbitrary packed entry type.
// Storage is not reset; only pointers and occupancy are.
module fp_misc_fifo #(
    parameter int  DEPTH   = 2,
    parameter type entry_t = logic
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  logic   pop,
    input  entry_t din,
    output entry_t dout,
    output logic   full,
    output logic   empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               do_push;
    logic               do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    // Entry storage written at the tail on an accepted push.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fp_misc_pipe.sv
// Misc FP unit: FMV, D2S, FSGNJ, FMIN/FMAX, I2F and S2D computed in one
// combinational stage, buffered for writeback with one cycle of latency.
module fp_misc_pipe
    import fpu_types::*;
#(
    parameter int DEPTH     = 2,
    parameter int INT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  fp_misc_pipe_inputs_t args,
    input  logic                 issue_new_request,
    input  id_t                  issue_id,
    output logic                 issue_ready,
    input  logic                 wb_ack,
    output logic                 wb_done,
    output id_t                  wb_id,
    output fp_misc_wb_payload_t  wb_payload
);

    localparam int IC_W = $clog2(INT_WIDTH) + 1;

    fp_misc_wb_payload_t   res;
    fp_misc_entry_t        entry_in;
    fp_misc_entry_t        entry_out;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  accept;

    logic [INT_WIDTH-1:0]  int_abs;
    logic [IC_W-1:0]       int_clz;
    logic                  int_zero;

    logic [FLEN_F-1:0]     sgnj_a_f;
    logic                  sgnj_b_sign_f;
    logic                  sign1;
    logic                  sign2;
    logic                  pick_rs2;

    assign int_abs  = args.int_rs_abs[INT_WIDTH-1:0];
    assign int_zero = (int_abs == '0);

    clz #(.WIDTH(INT_WIDTH)) u_clz (
        .value (int_abs),
        .count (int_clz)
    );

    // Unboxed singles: rs1 reads as canonical NaN, rs2 contributes sign 0.
    assign sgnj_a_f      = is_boxed(args.rs1) ? args.rs1[FLEN_F-1:0] : CANONICAL_NAN_F;
    assign sgnj_b_sign_f = is_boxed(args.rs2) ? args.rs2[FLEN_F-1] : 1'b0;

    assign sign1 = args.single ? args.rs1[FLEN_F-1] : args.rs1[FLEN-1];
    assign sign2 = args.single ? args.rs2[FLEN_F-1] : args.rs2[FLEN-1];

    // Min/max selection; swap comes from the upstream comparator (rs2 > rs1),
    // zeros are resolved here so that -0 orders below +0.
    always_comb begin
        pick_rs2 = 1'b0;
        if (args.rs1_special.is_zero && args.rs2_special.is_zero)
            pick_rs2 = args.rm[0] ? sign1 : sign2;
        else
            pick_rs2 = args.rm[0] ? args.swap : ~args.swap;
    end

    // Result datapath, priority fmv > d2s > fsgnj > fminmax > i2f > s2d.
    always_comb begin
        res                 = '0;
        res.rm              = args.rm;
        res.ignore_max_expo = 1'b1;
        if (args.fmv) begin
            res.hidden = 1'b0;
            if (args.single)
                res.rd = {{(FLEN-FLEN_F){1'b1}}, args.int_rs[FLEN_F-1:0]};
            else if (INT_WIDTH == 64)
                res.rd = args.int_rs;
            else
                res.rd = {{(FLEN-FLEN_F){1'b0}}, args.int_rs[FLEN_F-1:0]};
        end else if (args.d2s) begin
            res.hidden         = 1'b1;
            res.d2s            = 1'b1;
            res.fflags[NV_BIT] = args.rs1_special.is_snan;
            res.rd             = args.rs1_special.is_nan ? CANONICAL_NAN : args.rs1;
        end else if (args.fsgnj) begin
            res.hidden = 1'b1;
            if (args.single)
                res.rd = {{(FLEN-FLEN_F){1'b1}},
                          sgnj_sign(args.rm, sgnj_a_f[FLEN_F-1], sgnj_b_sign_f),
                          sgnj_a_f[FLEN_F-2:0]};
            else
                res.rd = {sgnj_sign(args.rm, args.rs1[FLEN-1], args.rs2[FLEN-1]),
                          args.rs1[FLEN-2:0]};
        end else if (args.fminmax) begin
            res.hidden         = 1'b1;
            res.fflags[NV_BIT] = args.rs1_special.is_snan | args.rs2_special.is_snan;
            if (args.rs1_special.is_nan && args.rs2_special.is_nan)
                res.rd = args.single ? {{(FLEN-FLEN_F){1'b1}}, CANONICAL_NAN_F} : CANONICAL_NAN;
            else if (args.rs1_special.is_nan)
                res.rd = args.rs2;
            else if (args.rs2_special.is_nan)
                res.rd = args.rs1;
            else
                res.rd = pick_rs2 ? args.rs2 : args.rs1;
        end else if (args.i2f) begin
            res.hidden = 1'b0;
            if (int_zero) begin
                res.rd  = {args.i2f_sign, {(FLEN-1){1'b0}}};
                res.clz = '0;
            end else begin
                res.rd[FLEN-1]                       = args.i2f_sign;
                res.rd[FLEN-2 -: EXPO_WIDTH]         = EXPO_WIDTH'(BIAS + INT_WIDTH);
                res.clz                              = CLZ_WIDTH'(int_clz) + CLZ_WIDTH'(1);
                if (INT_WIDTH == 64) begin
                    // Twelve low bits overflow the fraction: guard, round, sticky.
                    res.rd[FRAC_WIDTH-1:0] = args.int_rs_abs[63:12];
                    res.grs                = {args.int_rs_abs[11], args.int_rs_abs[10],
                                              |args.int_rs_abs[9:0]};
                end else begin
                    res.rd[FRAC_WIDTH-1:0] = {args.int_rs_abs[31:0], 20'b0};
                end
            end
        end else begin
            res.hidden         = 1'b1;
            res.fflags[NV_BIT] = args.rs1_special.is_snan;
            res.rd             = args.rs1;
        end
    end

    // Readiness depends only on registered occupancy, never on wb_ack.
    assign issue_ready = ~fifo_full;
    assign accept      = issue_new_request & issue_ready;
    assign entry_in    = '{id: issue_id, payload: res};

    fp_misc_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (fp_misc_entry_t)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .pop   (wb_ack),
        .din   (entry_in),
        .dout  (entry_out),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign wb_done    = ~fifo_empty;
    assign wb_id      = entry_out.id;
    assign wb_payload = entry_out.payload;

endmodule

// File: tb/tb_fp_misc_pipe.sv
// Directed bench for fp_misc_pipe (DEPTH=2, INT_WIDTH=64).
module tb_fp_misc_pipe;
    import fpu_types::*;

    logic                 clk = 1'b0;
    logic                 rst;
    fp_misc_pipe_inputs_t args;
    logic                 issue_new_request;
    id_t                  issue_id;
    logic                 issue_ready;
    logic                 wb_ack;
    logic                 wb_done;
    id_t                  wb_id;
    fp_misc_wb_payload_t  wb_payload;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fp_misc_pipe #(.DEPTH(2), .INT_WIDTH(64)) dut (
        .clk               (clk),
        .rst               (rst),
        .args              (args),
        .issue_new_request (issue_new_request),
        .issue_id          (issue_id),
        .issue_ready       (issue_ready),
        .wb_ack            (wb_ack),
        .wb_done           (wb_done),
        .wb_id             (wb_id),
        .wb_payload        (wb_payload)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic fp_misc_pipe_inputs_t blank();
        fp_misc_pipe_inputs_t a;
        a = '0;
        return a;
    endfunction

    function automatic fp_misc_pipe_inputs_t fmv_op(input logic [63:0] v);
        fp_misc_pipe_inputs_t a;
        a        = '0;
        a.fmv    = 1'b1;
        a.single = 1'b1;
        a.int_rs = v;
        return a;
    endfunction

    task automatic issue_op(input id_t id, input fp_misc_pipe_inputs_t a);
        @(negedge clk);
        args              = a;
        issue_id          = id;
        issue_new_request = 1'b1;
        @(posedge clk);
        #1;
        issue_new_request = 1'b0;
    endtask

    task automatic pop_head();
        @(negedge clk);
        wb_ack = 1'b1;
        @(posedge clk);
        #1;
        wb_ack = 1'b0;
    endtask

    fp_misc_pipe_inputs_t a;

    initial begin
        rst               = 1'b0;
        args              = '0;
        issue_new_request = 1'b0;
        issue_id          = '0;
        wb_ack            = 1'b0;
        #1;
        check_val("rst_done", 64'(wb_done), 64'd0);
        check_val("rst_ready", 64'(issue_ready), 64'd1);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // ack while empty must be ignored
        pop_head();
        check_val("ack_empty_done", 64'(wb_done), 64'd0);

        // FSGNJN single
        a = blank(); a.fsgnj = 1; a.single = 1; a.rm = 3'b001;
        a.rs1 = 64'hFFFFFFFF_3F800000; a.rs2 = 64'hFFFFFFFF_40000000;
        issue_op(4'd1, a);
        check_val("sgnjn_done", 64'(wb_done), 64'd1);
        check_val("sgnjn_id", 64'(wb_id), 64'd1);
        check_val("sgnjn_rd", wb_payload.rd, 64'hFFFFFFFF_BF800000);
        check_val("sgnjn_flags", 64'(wb_payload.fflags), 64'd0);
        check_val("sgnjn_hidden", 64'(wb_payload.hidden), 64'd1);
        check_val("sgnjn_rm", 64'(wb_payload.rm), 64'd1);
        check_val("const_fields", 64'({wb_payload.expo_overflow, wb_payload.carry, wb_payload.safe,
                  wb_payload.right_shift, wb_payload.subnormal, wb_payload.ignore_max_expo}), 64'd1);
        pop_head();
        check_val("sgnjn_popped", 64'(wb_done), 64'd0);

        // FSGNJX with unboxed rs1 -> canonical NaN magnitude
        a = blank(); a.fsgnj = 1; a.single = 1; a.rm = 3'b010;
        a.rs1 = 64'h00000000_3F800000; a.rs2 = 64'hFFFFFFFF_C0000000;
        issue_op(4'd2, a);
        check_val("sgnjx_unboxed_rd", wb_payload.rd, 64'hFFFFFFFF_FFC00000);
        pop_head();

        // FSGNJ with unboxed rs2 -> sign 0
        a = blank(); a.fsgnj = 1; a.single = 1; a.rm = 3'b000;
        a.rs1 = 64'hFFFFFFFF_BF800000; a.rs2 = 64'h00000000_C0000000;
        issue_op(4'd2, a);
        check_val("sgnj_unboxed_rd", wb_payload.rd, 64'hFFFFFFFF_3F800000);
        pop_head();

        // FMAX sNaN vs 1.0 single
        a = blank(); a.fminmax = 1; a.single = 1; a.rm = 3'b001;
        a.rs1 = 64'hFFFFFFFF_7FA00000; a.rs1_special = '{is_nan: 1, is_snan: 1, is_zero: 0};
        a.rs2 = 64'hFFFFFFFF_3F800000;
        issue_op(4'd3, a);
        check_val("fmax_snan_rd", wb_payload.rd, 64'hFFFFFFFF_3F800000);
        check_val("fmax_snan_flags", 64'(wb_payload.fflags), 64'h10);
        pop_head();

        // FMAX both qNaN double
        a = blank(); a.fminmax = 1; a.rm = 3'b001;
        a.rs1 = 64'h7FF80000_00000001; a.rs1_special = '{is_nan: 1, is_snan: 0, is_zero: 0};
        a.rs2 = 64'h7FF80000_00000002; a.rs2_special = '{is_nan: 1, is_snan: 0, is_zero: 0};
        issue_op(4'd4, a);
        check_val("fmax_qnan_rd", wb_payload.rd, 64'h7FF80000_00000000);
        check_val("fmax_qnan_flags", 64'(wb_payload.fflags), 64'd0);
        check_val("fmax_qnan_hidden", 64'(wb_payload.hidden), 64'd1);
        pop_head();

        // FMIN / FMAX on +0 vs -0
        a = blank(); a.fminmax = 1; a.rm = 3'b000;
        a.rs1 = 64'h0; a.rs1_special.is_zero = 1;
        a.rs2 = 64'h80000000_00000000; a.rs2_special.is_zero = 1;
        issue_op(4'd5, a);
        check_val("fmin_zero_rd", wb_payload.rd, 64'h80000000_00000000);
        pop_head();
        a.rm = 3'b001;
        issue_op(4'd5, a);
        check_val("fmax_zero_rd", wb_payload.rd, 64'h0);
        pop_head();

        // FMIN / FMAX on 1.0 vs 2.0 (swap = rs2 > rs1)
        a = blank(); a.fminmax = 1; a.rm = 3'b000; a.swap = 1;
        a.rs1 = 64'h3FF00000_00000000; a.rs2 = 64'h40000000_00000000;
        issue_op(4'd6, a);
        check_val("fmin_norm_rd", wb_payload.rd, 64'h3FF00000_00000000);
        pop_head();
        a.rm = 3'b001;
        issue_op(4'd6, a);
        check_val("fmax_norm_rd", wb_payload.rd, 64'h40000000_00000000);
        pop_head();

        // I2F zero, one, and a value spilling into grs
        a = blank(); a.i2f = 1; a.int_rs_abs = 64'd0;
        issue_op(4'd7, a);
        check_val("i2f0_expo", 64'(wb_payload.rd[62:52]), 64'd0);
        check_val("i2f0_clz", 64'(wb_payload.clz), 64'd0);
        pop_head();
        a.int_rs_abs = 64'd1;
        issue_op(4'd7, a);
        check_val("i2f1_expo", 64'(wb_payload.rd[62:52]), 64'd1087);
        check_val("i2f1_clz", 64'(wb_payload.clz), 64'd64);
        check_val("i2f1_grs", 64'(wb_payload.grs), 64'b001);
        check_val("i2f1_frac", 64'(wb_payload.rd[51:0]), 64'd0);
        pop_head();
        a.int_rs_abs = 64'h80000000_00000C00; a.i2f_sign = 1;
        issue_op(4'd7, a);
        check_val("i2fm_sign", 64'(wb_payload.rd[63]), 64'd1);
        check_val("i2fm_clz", 64'(wb_payload.clz), 64'd1);
        check_val("i2fm_frac", 64'(wb_payload.rd[51:0]), 64'h8_0000_0000_0000);
        check_val("i2fm_grs", 64'(wb_payload.grs), 64'b110);
        check_val("i2fm_hidden", 64'(wb_payload.hidden), 64'd0);
        pop_head();

        // FMV single and double
        a = fmv_op(64'h12345678_9ABCDEF0);
        issue_op(4'd8, a);
        check_val("fmv_s_rd", wb_payload.rd, 64'hFFFFFFFF_9ABCDEF0);
        check_val("fmv_s_hidden", 64'(wb_payload.hidden), 64'd0);
        pop_head();
        a.single = 0;
        issue_op(4'd8, a);
        check_val("fmv_d_rd", wb_payload.rd, 64'h12345678_9ABCDEF0);
        pop_head();

        // FMV wins over FSGNJ
        a = fmv_op(64'd1); a.fsgnj = 1; a.rs1 = 64'hFFFFFFFF_3F800000;
        issue_op(4'd9, a);
        check_val("prio_fmv_rd", wb_payload.rd, 64'hFFFFFFFF_00000001);
        pop_head();

        // D2S canonicalizes sNaN
        a = blank(); a.d2s = 1;
        a.rs1 = 64'h7FF40000_00000000; a.rs1_special = '{is_nan: 1, is_snan: 1, is_zero: 0};
        issue_op(4'd10, a);
        check_val("d2s_rd", wb_payload.rd, 64'h7FF80000_00000000);
        check_val("d2s_flag", 64'(wb_payload.d2s), 64'd1);
        check_val("d2s_nv", 64'(wb_payload.fflags), 64'h10);
        pop_head();

        // S2D passes rs1, nv on sNaN
        a.d2s = 0; a.s2d = 1;
        issue_op(4'd11, a);
        check_val("s2d_rd", wb_payload.rd, 64'h7FF40000_00000000);
        check_val("s2d_d2s", 64'(wb_payload.d2s), 64'd0);
        check_val("s2d_nv", 64'(wb_payload.fflags), 64'h10);
        pop_head();

        // Back-to-back ids 3,4,5 with no ack; then full + ack + issue
        @(negedge clk);
        args = fmv_op(64'd3); issue_id = 4'd3; issue_new_request = 1;
        check_val("b2b_ready3", 64'(issue_ready), 64'd1);
        @(negedge clk);
        args = fmv_op(64'd4); issue_id = 4'd4;
        check_val("b2b_ready4", 64'(issue_ready), 64'd1);
        @(negedge clk);
        args = fmv_op(64'd5); issue_id = 4'd5;
        check_val("b2b_ready_drop", 64'(issue_ready), 64'd0);
        check_val("b2b_head3", 64'(wb_id), 64'd3);
        @(negedge clk);
        check_val("b2b_stall", 64'(issue_ready), 64'd0);
        check_val("b2b_head3_hold", 64'(wb_id), 64'd3);
        wb_ack = 1;
        @(negedge clk);
        check_val("full_pop_head4", 64'(wb_id), 64'd4);
        check_val("full_pop_ready", 64'(issue_ready), 64'd1);
        @(negedge clk);
        issue_new_request = 0;
        check_val("b2b_head5", 64'(wb_id), 64'd5);
        check_val("b2b_head5_rd", wb_payload.rd, 64'hFFFFFFFF_00000005);
        check_val("b2b_head5_done", 64'(wb_done), 64'd1);
        @(negedge clk);
        wb_ack = 0;
        check_val("b2b_drained", 64'(wb_done), 64'd0);

        // Reset with two entries buffered
        issue_op(4'd1, fmv_op(64'd1));
        issue_op(4'd2, fmv_op(64'd2));
        check_val("pre_rst_full", 64'(issue_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_val("mid_rst_done", 64'(wb_done), 64'd0);
        check_val("mid_rst_ready", 64'(issue_ready), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        issue_op(4'd7, fmv_op(64'd7));
        check_val("post_rst_done", 64'(wb_done), 64'd1);
        check_val("post_rst_id", 64'(wb_id), 64'd7);
        pop_head();
        check_val("post_rst_empty", 64'(wb_done), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
